updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised reversible (up/down) counter and the successor of the fixed 16-bit reversible counter.
- Runs on the main board clock. An internal prescaler generates count-enable ticks, so no derived clock is needed.
- Adds the following over the fixed counter:
  - width and modulus parameters;
  - a binary/BCD mode;
  - a count enable;
  - a synchronous parallel load;
  - a registered wrap pulse.
- Output `cnt` feeds the hex/BCD display path directly (4 digits per 16 bits).

Parameters:
- WIDTH, 16: counter width in bits. Must be a multiple of 4 when MODE_BCD=1.
- MODE_BCD, 0: 0 = binary counting; 1 = packed BCD counting, each nibble 0..9.
- MAX_VAL, {WIDTH{1'b1}}: binary terminal value; the count range is 0..MAX_VAL. Ignored when MODE_BCD=1, where the terminal value is all nibbles = 9.
- PRESCALE, 10_000_000: clk cycles per count tick (100 ms at 100 MHz). Must be ≥1; 1 = tick every enabled cycle.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; gates the prescaler and counting.
- s  in  1  direction: 0 = up, 1 = down.
- ld  in  1  synchronous parallel load strobe.
- din  in  WIDTH  load value.
- cnt  out  WIDTH  current count, registered.
- Rc  out  1  terminal-count level, combinational from `cnt` and `s`.
- wrap  out  1  registered one-cycle pulse on wrap-around.
- tick  out  1  registered prescaler tick, for display or debug use.

Behaviour:
- Reset (asynchronous, rst=1): cnt=0, prescaler=0, tick=0, wrap=0.
  - Rc then follows its own equation: Rc=1 if s=1 (down), else 0.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1 and holds its value while en=0.
  - tick=1 for exactly one cycle, on the cycle after the prescaler reaches PRESCALE-1; the prescaler returns to 0 on that same cycle.
  - PRESCALE=1: tick = en registered.
- Count update happens on the clock edge where tick=1 (internal tick_next=1) and ld=0:
  - Up (s=0): if cnt==TERM then cnt←0 and wrap←1; else cnt←cnt+1.
  - Down (s=1): if cnt==0 then cnt←TERM and wrap←1; else cnt←cnt-1.
  - TERM = MAX_VAL in binary mode, all-9s in BCD mode.
  - Latency: cnt changes on the same edge that asserts tick.
- wrap is 1 only on the cycle following a wrapping update; 0 otherwise.
- BCD arithmetic:
  - Per-nibble carry/borrow chain.
  - Up: a nibble at 9 goes to 0 and carries into the next nibble.
  - Down: a nibble at 0 goes to 9 and borrows from the next nibble.
  - Full wrap only when all nibbles are 9 (up) or all nibbles are 0 (down).
- Load: when ld=1, on that edge:
  - cnt←sanitised din;
  - prescaler←0;
  - wrap←0;
  - any coincident tick update is discarded (load has priority over count).
  - Load works regardless of en.
- Load sanitising:
  - Binary: din>MAX_VAL loads MAX_VAL.
  - BCD: any nibble >9 loads 9 in that nibble; other nibbles load unchanged.
- Rc (combinational): (s==0 && cnt==TERM) || (s==1 && cnt==0).
  - A change of s alone changes Rc immediately; cnt is unaffected.
- en=0: cnt, prescaler and tick hold.
  - tick=0 while en=0.
  - Rc still tracks s.
- Direction change mid-prescale: takes effect at the next tick; the prescaler is not reset.
- Reset asserted mid-operation: immediate clear regardless of clk; counting resumes from 0 after rst deasserts, with a full PRESCALE interval before the first tick.
- Non-power-of-2 MAX_VAL: values above MAX_VAL are never reached by counting.
- Implementation constraints:
  - No derived clocks; single clock domain.
  - Prescaler width = clog2(PRESCALE), minimum 1.

Test Plan:
- **Binary up wrap.** WIDTH=8, MAX_VAL=9, PRESCALE=4, en=1, s=0 from reset.
  - Each tick falls every 4th cycle; after 9 ticks cnt=9 and Rc=1.
  - The 10th tick gives cnt=0, wrap=1 for one cycle, Rc=0.
- **Binary down from reset.** Same config, s=1.
  - Rc=1 immediately after reset.
  - First tick: cnt=9, wrap pulses.
  - Second tick: cnt=8.
- **BCD mode.** WIDTH=8, MODE_BCD=1, PRESCALE=1, en=1.
  - Up: load 0x19 → next cnt=0x20; load 0x99 → next cnt=0x00 with wrap=1.
  - Down (s=1): load 0x10 → next cnt=0x09.
- **Load.**
  - ld=1 coincident with tick, din=0x05 (binary, MAX_VAL=9): cnt=5 with no increment, and the next tick is 4 cycles later.
  - Load din=0x3C: cnt=9 (clamped).
  - BCD: load 0xAB → cnt=0x99.
- **Enable / direction.**
  - en=0 for 10 cycles mid-prescale: cnt, tick and prescaler frozen; counting resumes from the frozen phase.
  - Toggle s while cnt=0: Rc follows s combinationally.
- **Asynchronous reset.** Assert rst between clock edges while cnt=7.
  - cnt=0 immediately.
  - After release, the first tick comes exactly PRESCALE cycles later.

Source files
------------

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised binary/BCD up/down counter with prescaler, load and wrap pulse
module updown_counter_param #(
   parameter int               WIDTH    = 16,
   parameter bit               MODE_BCD = 1'b0,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter int               PRESCALE = 10_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             s,
   input  logic             ld,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] cnt,
   output logic             Rc,
   output logic             wrap,
   output logic             tick
);
   localparam int            NIB     = WIDTH / 4;
   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   function automatic logic [WIDTH-1:0] all_nines();
      logic [WIDTH-1:0] v = '0;
      for (int i = 0; i < NIB; i++) v[4*i +: 4] = 4'h9;
      return v;
   endfunction

   localparam logic [WIDTH-1:0] TERM = MODE_BCD ? all_nines() : MAX_VAL;

   // Ripple a carry (up) or borrow (down) through the nibbles, stopping at the first one that absorbs it.
   function automatic logic [WIDTH-1:0] bcd_step(input logic [WIDTH-1:0] v, input logic down);
      logic [WIDTH-1:0] r = v;
      logic             c = 1'b1;
      for (int i = 0; i < NIB; i++) begin
         if (c) begin
            if (!down) begin
               if (v[4*i +: 4] >= 4'h9) r[4*i +: 4] = 4'h0;
               else begin
                  r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (v[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'h9;
               else begin
                  r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] sanitise(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r = v;
      if (MODE_BCD) begin
         for (int i = 0; i < NIB; i++)
            if (v[4*i +: 4] > 4'h9) r[4*i +: 4] = 4'h9;
      end else if (v > MAX_VAL) begin
         r = MAX_VAL;
      end
      return r;
   endfunction

   logic [PW-1:0]    presc;
   logic             tick_next;
   logic             at_edge;
   logic [WIDTH-1:0] cnt_next;

   assign tick_next = en && (presc == PS_LAST);
   assign at_edge   = s ? (cnt == '0) : (cnt == TERM);
   assign Rc        = at_edge;

   always_comb begin
      cnt_next = cnt;
      if (at_edge)       cnt_next = s ? TERM : '0;
      else if (MODE_BCD) cnt_next = bcd_step(cnt, s);
      else if (s)        cnt_next = cnt - WIDTH'(1);
      else               cnt_next = cnt + WIDTH'(1);
   end

   // Load outranks a coincident tick and restarts the prescale interval.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         presc <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (ld) begin
         cnt   <= sanitise(din);
         presc <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (tick_next) begin
         cnt   <= cnt_next;
         presc <= '0;
         tick  <= 1'b1;
         wrap  <= at_edge;
      end else begin
         if (en) presc <= presc + PW'(1);
         tick <= 1'b0;
         wrap <= 1'b0;
      end
   end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - directed and random check of binary and BCD counter instances
module tb_updown_counter_param;
   localparam int A_PS  = 4;
   localparam int A_MAX = 9;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_a, s_a, ld_a, rc_a, wrap_a, tick_a;
   logic [7:0] din_a, cnt_a;
   logic       en_b, s_b, ld_b, rc_b, wrap_b, tick_b;
   logic [7:0] din_b, cnt_b;

   int   vectors = 0;
   int   errors  = 0;

   int   m_a_cnt, m_a_ph;
   logic m_a_tick, m_a_wrap;
   int   m_b_dec;
   logic m_b_tick, m_b_wrap;

   always #5 clk = ~clk;

   updown_counter_param #(.WIDTH(8), .MODE_BCD(1'b0), .MAX_VAL(8'd9), .PRESCALE(A_PS)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .s(s_a), .ld(ld_a), .din(din_a),
      .cnt(cnt_a), .Rc(rc_a), .wrap(wrap_a), .tick(tick_a));

   updown_counter_param #(.WIDTH(8), .MODE_BCD(1'b1), .PRESCALE(1)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .s(s_b), .ld(ld_b), .din(din_b),
      .cnt(cnt_b), .Rc(rc_b), .wrap(wrap_b), .tick(tick_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int to_dec(input logic [7:0] v);
      int hi = int'(v[7:4]);
      int lo = int'(v[3:0]);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      return hi * 10 + lo;
   endfunction

   function automatic logic [7:0] to_bcd(input int d);
      return 8'((d / 10) * 16 + (d % 10));
   endfunction

   task automatic model_reset();
      m_a_cnt = 0; m_a_ph = 0; m_a_tick = 1'b0; m_a_wrap = 1'b0;
      m_b_dec = 0; m_b_tick = 1'b0; m_b_wrap = 1'b0;
   endtask

   task automatic model_a();
      if (ld_a) begin
         m_a_cnt = (din_a > 8'(A_MAX)) ? A_MAX : int'(din_a);
         m_a_ph = 0; m_a_tick = 1'b0; m_a_wrap = 1'b0;
      end else if (en_a && m_a_ph == A_PS - 1) begin
         m_a_ph   = 0;
         m_a_tick = 1'b1;
         m_a_wrap = s_a ? (m_a_cnt == 0) : (m_a_cnt == A_MAX);
         m_a_cnt  = s_a ? (m_a_cnt + A_MAX) % (A_MAX + 1) : (m_a_cnt + 1) % (A_MAX + 1);
      end else begin
         if (en_a) m_a_ph++;
         m_a_tick = 1'b0; m_a_wrap = 1'b0;
      end
   endtask

   task automatic model_b();
      if (ld_b) begin
         m_b_dec = to_dec(din_b); m_b_tick = 1'b0; m_b_wrap = 1'b0;
      end else if (en_b) begin
         m_b_tick = 1'b1;
         m_b_wrap = s_b ? (m_b_dec == 0) : (m_b_dec == 99);
         m_b_dec  = s_b ? (m_b_dec + 99) % 100 : (m_b_dec + 1) % 100;
      end else begin
         m_b_tick = 1'b0; m_b_wrap = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_a();
      model_b();
      #1;
      chk("a_cnt",  32'(cnt_a),  32'(m_a_cnt));
      chk("a_tick", 32'(tick_a), 32'(m_a_tick));
      chk("a_wrap", 32'(wrap_a), 32'(m_a_wrap));
      chk("a_rc",   32'(rc_a),   32'(s_a ? (m_a_cnt == 0) : (m_a_cnt == A_MAX)));
      chk("b_cnt",  32'(cnt_b),  32'(to_bcd(m_b_dec)));
      chk("b_tick", 32'(tick_b), 32'(m_b_tick));
      chk("b_wrap", 32'(wrap_b), 32'(m_b_wrap));
      chk("b_rc",   32'(rc_b),   32'(s_b ? (m_b_dec == 0) : (m_b_dec == 99)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      en_a = 1'b0; s_a = 1'b0; ld_a = 1'b0; din_a = 8'h00;
      en_b = 1'b0; s_b = 1'b0; ld_b = 1'b0; din_b = 8'h00;
      model_reset();
      #12;
      chk("rst_cnt",  32'(cnt_a),  0);
      chk("rst_tick", 32'(tick_a), 0);
      chk("rst_wrap", 32'(wrap_a), 0);
      chk("rst_rc_up", 32'(rc_a),  0);
      s_a = 1'b1; #1;
      chk("rst_rc_down", 32'(rc_a), 1);
      s_a = 1'b0;
      #4 rst = 1'b0;
      en_a = 1'b1;

      // Binary up: tick every 4th cycle, cnt=9 after 9 ticks, wrap on the 10th.
      for (int i = 1; i <= 40; i++) begin
         step();
         if (i == 3)  chk("up_first_tick_pending", 32'(tick_a), 0);
         if (i == 4)  chk("up_first_tick", 32'(cnt_a), 1);
         if (i == 36) chk("up_at_nine", 32'(cnt_a), 9);
         if (i == 36) chk("up_rc_high", 32'(rc_a), 1);
         if (i == 40) chk("up_wrap_cnt", 32'(cnt_a), 0);
         if (i == 40) chk("up_wrap_pulse", 32'(wrap_a), 1);
      end
      step();
      chk("up_wrap_one_cycle", 32'(wrap_a), 0);

      // Async reset while cnt=7, then count down from reset.
      ld_a = 1'b1; din_a = 8'd7; step();
      ld_a = 1'b0; step(); step();
      chk("pre_reset_cnt", 32'(cnt_a), 7);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_reset_cnt", 32'(cnt_a), 0);
      s_a = 1'b1; #1;
      chk("down_rc_after_reset", 32'(rc_a), 1);
      #1 rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 3) chk("down_no_early_tick", 32'(tick_a), 0);
         if (i == 4) chk("down_first_cnt", 32'(cnt_a), 9);
         if (i == 4) chk("down_first_wrap", 32'(wrap_a), 1);
         if (i == 8) chk("down_second_cnt", 32'(cnt_a), 8);
      end

      // Load on the tick edge: no increment, next tick 4 cycles later.
      s_a = 1'b0;
      step(); step(); step();
      ld_a = 1'b1; din_a = 8'h05; step();
      ld_a = 1'b0;
      chk("load_on_tick", 32'(cnt_a), 5);
      for (int i = 1; i <= 4; i++) begin
         step();
         if (i == 3) chk("load_no_tick_yet", 32'(tick_a), 0);
         if (i == 4) chk("load_next_tick_cnt", 32'(cnt_a), 6);
      end
      ld_a = 1'b1; din_a = 8'h3C; step();
      ld_a = 1'b0;
      chk("load_clamp", 32'(cnt_a), 9);

      // Freeze mid-prescale, then resume from the frozen phase.
      step(); step();
      en_a = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("freeze_cnt", 32'(cnt_a), 9);
      en_a = 1'b1;
      step(); step();
      chk("resume_wrap_cnt", 32'(cnt_a), 0);
      chk("resume_wrap_pulse", 32'(wrap_a), 1);
      s_a = 1'b1; #1;
      chk("rc_follows_s_down", 32'(rc_a), 1);
      s_a = 1'b0; #1;
      chk("rc_follows_s_up", 32'(rc_a), 0);

      // BCD directed loads and carries.
      en_b = 1'b1; s_b = 1'b0;
      ld_b = 1'b1; din_b = 8'h19; step();
      ld_b = 1'b0; step();
      chk("bcd_carry", 32'(cnt_b), 32'h20);
      ld_b = 1'b1; din_b = 8'h99; step();
      ld_b = 1'b0; step();
      chk("bcd_wrap_cnt", 32'(cnt_b), 32'h00);
      chk("bcd_wrap_pulse", 32'(wrap_b), 1);
      s_b = 1'b1;
      ld_b = 1'b1; din_b = 8'h10; step();
      ld_b = 1'b0; step();
      chk("bcd_borrow", 32'(cnt_b), 32'h09);
      ld_b = 1'b1; din_b = 8'hAB; step();
      ld_b = 1'b0;
      chk("bcd_clamp", 32'(cnt_b), 32'h99);

      // Random traffic on both instances.
      for (int i = 0; i < 600; i++) begin
         en_a  = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) == 0) s_a = ~s_a;
         ld_a  = ($urandom_range(0, 19) == 0);
         din_a = 8'($urandom);
         en_b  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) s_b = ~s_b;
         ld_b  = ($urandom_range(0, 29) == 0);
         din_b = 8'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
